mem_lsu: RTL and testbench

- MEM stage directly downstream of EXE.
- Holds the EX/MEM pipeline register and issues loads/stores on an SRAM-like data bus (req / addr_ok / data_ok).
- Aligns and extends load data; detects address-alignment exceptions.
- Drives the mem_* forwarding signals that EXE consumes for GPR, HI/LO and CP0 bypass.

---
 rtl/mem_pkg.sv | 58 +++++
 rtl/load_align.sv | 34 +++
 rtl/mem_lsu.sv | 203 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Op codes, FSM states and bus size encodings live here so the top and the aligner agree.
package mem_pkg;

   typedef enum logic [3:0] {
      OpNone = 4'd0,
      OpLb   = 4'd1,
      OpLbu  = 4'd2,
      OpLh   = 4'd3,
      OpLhu  = 4'd4,
      OpLw   = 4'd5,
      OpSb   = 4'd6,
      OpSh   = 4'd7,
      OpSw   = 4'd8
   } memop_t;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StReq    = 2'd1,
      StWait   = 2'd2,
      StCancel = 2'd3
   } lsu_state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   function automatic logic is_load(input memop_t op);
      case (op)
         OpLb, OpLbu, OpLh, OpLhu, OpLw: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input memop_t op);
      case (op)
         OpSb, OpSh, OpSw: return 1'b1;
         default:          return 1'b0;
      endcase
   endfunction

   function automatic logic is_misaligned(input memop_t op, input logic [1:0] addr);
      case (op)
         OpLh, OpLhu, OpSh: return addr[0];
         OpLw, OpSw:        return (addr != 2'b00);
         default:           return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] op_size(input memop_t op);
      case (op)
         OpLb, OpLbu, OpSb: return SZ_B;
         OpLh, OpLhu, OpSh: return SZ_H;
         default:           return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian byte/half lane select with sign or zero extension for loads.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr,
   input  memop_t      i_memop,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      unique case (i_addr)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

      o_result = i_rdata;
      case (i_memop)
         OpLb:    o_result = {{24{w_byte[7]}}, w_byte};
         OpLbu:   o_result = {24'h000000, w_byte};
         OpLh:    o_result = {{16{w_half[15]}}, w_half};
         OpLhu:   o_result = {16'h0000, w_half};
         default: o_result = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: EX/MEM register, SRAM-like data bus master, load alignment and EXE bypass outputs.
// The bus FSM holds the stage (mem_stall_o) from request until the response has been consumed.
module mem_lsu
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              ex_valid_i,
   input  logic [DATA_W-1:0] ex_aluout_i,
   input  logic [DATA_W-1:0] ex_rdata2_i,
   input  logic [4:0]        ex_waddr_i,
   input  logic              ex_we_i,
   input  logic [3:0]        ex_memop_i,
   input  logic [DATA_W-1:0] ex_hi_data_i,
   input  logic [DATA_W-1:0] ex_lo_data_i,
   input  logic [1:0]        ex_hilo_we_i,
   input  logic [4:0]        ex_rd_i,
   input  logic              ex_wcp0_i,
   input  logic [DATA_W-1:0] ex_pc_i,
   input  logic              stall_i,
   input  logic              flush_i,

   output logic              data_req_o,
   output logic              data_wr_o,
   output logic [1:0]        data_size_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [DATA_W-1:0] data_wdata_o,
   input  logic              data_addr_ok_i,
   input  logic              data_data_ok_i,
   input  logic [DATA_W-1:0] data_rdata_i,

   output logic              mem_valid_o,
   output logic [4:0]        mem_waddr_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [1:0]        mem_hilo_we_o,
   output logic [DATA_W-1:0] mem_hi_alu_out_o,
   output logic [DATA_W-1:0] mem_lo_alu_out_o,
   output logic [4:0]        mem_rd_o,
   output logic              mem_wcp0_o,
   output logic [DATA_W-1:0] mem_pc_o,
   output logic              mem_stall_o,
   output logic              adel_o,
   output logic              ades_o,
   output logic [DATA_W-1:0] badvaddr_o
);

   lsu_state_t        r_state, w_state_next;
   logic              r_valid, r_we, r_wcp0, r_done;
   logic [DATA_W-1:0] r_aluout, r_rdata2, r_hi, r_lo, r_pc, r_buf;
   logic [4:0]        r_waddr, r_rd;
   logic [1:0]        r_hilo_we;
   memop_t            r_memop;

   memop_t            w_ex_op;
   logic              w_capture, w_start, w_latch;
   logic              w_load, w_store, w_misalign, w_exc;
   logic [DATA_W-1:0] w_aligned;

   assign w_ex_op   = memop_t'(ex_memop_i);
   assign w_capture = !stall_i && (r_state == StIdle);
   assign w_start   = w_capture && !flush_i && ex_valid_i && (w_ex_op != OpNone) &&
                      !is_misaligned(w_ex_op, ex_aluout_i[1:0]);

   // Bus FSM; w_latch marks a response that belongs to a live (unflushed) access.
   always_comb begin
      w_state_next = r_state;
      w_latch      = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_start) w_state_next = StReq;
         end
         StReq: begin
            if (data_addr_ok_i) begin
               if (data_data_ok_i) begin
                  w_state_next = StIdle;
                  w_latch      = !flush_i;
               end else if (flush_i) begin
                  w_state_next = StCancel;
               end else begin
                  w_state_next = StWait;
               end
            end else if (flush_i) begin
               w_state_next = StIdle;
            end
         end
         StWait: begin
            if (data_data_ok_i) begin
               w_state_next = StIdle;
               w_latch      = !flush_i;
            end else if (flush_i) begin
               w_state_next = StCancel;
            end
         end
         StCancel: begin
            if (data_data_ok_i) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= StIdle;
         r_valid   <= 1'b0;
         r_we      <= 1'b0;
         r_wcp0    <= 1'b0;
         r_done    <= 1'b0;
         r_aluout  <= '0;
         r_rdata2  <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_pc      <= '0;
         r_buf     <= '0;
         r_waddr   <= '0;
         r_rd      <= '0;
         r_hilo_we <= '0;
         r_memop   <= OpNone;
      end else begin
         r_state <= w_state_next;
         if (w_capture) begin
            r_done    <= 1'b0;
            r_valid   <= ex_valid_i;
            r_we      <= ex_we_i;
            r_wcp0    <= ex_wcp0_i;
            r_hilo_we <= ex_hilo_we_i;
            r_memop   <= w_ex_op;
            r_aluout  <= ex_aluout_i;
            r_rdata2  <= ex_rdata2_i;
            r_hi      <= ex_hi_data_i;
            r_lo      <= ex_lo_data_i;
            r_pc      <= ex_pc_i;
            r_waddr   <= ex_waddr_i;
            r_rd      <= ex_rd_i;
            if (flush_i) begin
               r_valid   <= 1'b0;
               r_we      <= 1'b0;
               r_wcp0    <= 1'b0;
               r_hilo_we <= 2'b00;
               r_memop   <= OpNone;
            end
         end else if ((r_state != StIdle) && flush_i) begin
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_wcp0    <= 1'b0;
            r_hilo_we <= 2'b00;
         end
         if (w_latch) begin
            r_buf  <= data_rdata_i;
            r_done <= 1'b1;
         end
      end
   end

   load_align u_load_align (
      .i_rdata  (r_buf),
      .i_addr   (r_aluout[1:0]),
      .i_memop  (r_memop),
      .o_result (w_aligned)
   );

   assign w_load     = is_load(r_memop);
   assign w_store    = is_store(r_memop);
   assign w_misalign = is_misaligned(r_memop, r_aluout[1:0]);
   assign adel_o     = r_valid && w_load && w_misalign;
   assign ades_o     = r_valid && w_store && w_misalign;
   assign w_exc      = adel_o || ades_o;
   assign badvaddr_o = w_exc ? r_aluout : '0;

   assign data_req_o  = (r_state == StReq);
   assign data_wr_o   = data_req_o && w_store;
   assign data_size_o = data_req_o ? op_size(r_memop) : 2'd0;
   assign data_addr_o = data_req_o ? r_aluout[ADDR_W-1:0] : '0;

   // Stores replicate the source lane so the slave can pick any byte/half lane.
   always_comb begin
      data_wdata_o = '0;
      if (data_req_o && w_store) begin
         case (r_memop)
            OpSb:    data_wdata_o = {4{r_rdata2[7:0]}};
            OpSh:    data_wdata_o = {2{r_rdata2[15:0]}};
            default: data_wdata_o = r_rdata2;
         endcase
      end
   end

   assign mem_stall_o      = (r_state != StIdle);
   assign mem_valid_o      = r_valid;
   assign mem_waddr_o      = r_waddr;
   assign mem_we_o         = r_we && !w_exc;
   assign mem_wdata_o      = (w_load && r_done) ? w_aligned : r_aluout;
   assign mem_hilo_we_o    = r_hilo_we;
   assign mem_hi_alu_out_o = r_hi;
   assign mem_lo_alu_out_o = r_lo;
   assign mem_rd_o         = r_rd;
   assign mem_wcp0_o       = r_wcp0;
   assign mem_pc_o         = r_pc;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: expected results are queued when an op is driven
// and popped when the stage releases its stall.
module tb_mem_lsu;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid_i, ex_we_i, ex_wcp0_i, stall_i, flush_i;
   logic [31:0] ex_aluout_i, ex_rdata2_i, ex_hi_data_i, ex_lo_data_i, ex_pc_i;
   logic [4:0]  ex_waddr_i, ex_rd_i;
   logic [3:0]  ex_memop_i;
   logic [1:0]  ex_hilo_we_i;
   logic        data_req_o, data_wr_o, data_addr_ok_i, data_data_ok_i;
   logic [1:0]  data_size_o;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
   logic        mem_valid_o, mem_we_o, mem_wcp0_o, mem_stall_o, adel_o, ades_o;
   logic [4:0]  mem_waddr_o, mem_rd_o;
   logic [31:0] mem_wdata_o, mem_hi_alu_out_o, mem_lo_alu_out_o, mem_pc_o, badvaddr_o;
   logic [1:0]  mem_hilo_we_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   mem_lsu dut (
      .clk              (clk),
      .rst              (rst),
      .ex_valid_i       (ex_valid_i),
      .ex_aluout_i      (ex_aluout_i),
      .ex_rdata2_i      (ex_rdata2_i),
      .ex_waddr_i       (ex_waddr_i),
      .ex_we_i          (ex_we_i),
      .ex_memop_i       (ex_memop_i),
      .ex_hi_data_i     (ex_hi_data_i),
      .ex_lo_data_i     (ex_lo_data_i),
      .ex_hilo_we_i     (ex_hilo_we_i),
      .ex_rd_i          (ex_rd_i),
      .ex_wcp0_i        (ex_wcp0_i),
      .ex_pc_i          (ex_pc_i),
      .stall_i          (stall_i),
      .flush_i          (flush_i),
      .data_req_o       (data_req_o),
      .data_wr_o        (data_wr_o),
      .data_size_o      (data_size_o),
      .data_addr_o      (data_addr_o),
      .data_wdata_o     (data_wdata_o),
      .data_addr_ok_i   (data_addr_ok_i),
      .data_data_ok_i   (data_data_ok_i),
      .data_rdata_i     (data_rdata_i),
      .mem_valid_o      (mem_valid_o),
      .mem_waddr_o      (mem_waddr_o),
      .mem_we_o         (mem_we_o),
      .mem_wdata_o      (mem_wdata_o),
      .mem_hilo_we_o    (mem_hilo_we_o),
      .mem_hi_alu_out_o (mem_hi_alu_out_o),
      .mem_lo_alu_out_o (mem_lo_alu_out_o),
      .mem_rd_o         (mem_rd_o),
      .mem_wcp0_o       (mem_wcp0_o),
      .mem_pc_o         (mem_pc_o),
      .mem_stall_o      (mem_stall_o),
      .adel_o           (adel_o),
      .ades_o           (ades_o),
      .badvaddr_o       (badvaddr_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      ex_valid_i   = 1'b0;
      ex_aluout_i  = '0;
      ex_rdata2_i  = '0;
      ex_waddr_i   = '0;
      ex_we_i      = 1'b0;
      ex_memop_i   = 4'd0;
      ex_hi_data_i = '0;
      ex_lo_data_i = '0;
      ex_hilo_we_i = '0;
      ex_rd_i      = '0;
      ex_wcp0_i    = 1'b0;
      ex_pc_i      = '0;
   endtask

   task automatic drive_op(input memop_t op, input logic [31:0] addr, input logic [31:0] rt);
      ex_valid_i   = 1'b1;
      ex_memop_i   = op;
      ex_aluout_i  = addr;
      ex_rdata2_i  = rt;
      ex_waddr_i   = 5'd7;
      ex_we_i      = 1'b1;
      ex_hi_data_i = addr ^ 32'hFFFF_0000;
      ex_lo_data_i = rt;
      ex_hilo_we_i = 2'b10;
      ex_rd_i      = 5'd12;
      ex_wcp0_i    = 1'b1;
      ex_pc_i      = 32'hBFC0_0000 + addr;
   endtask

   // One full access: addr_ok in REQ, data_ok the next cycle; checks the bus side in REQ.
   task automatic run_mem(input string tag, input memop_t op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rdata,
                          input logic wr, input logic [1:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp);
      int stall_cycles;
      logic [31:0] e;
      stall_cycles = 0;
      @(negedge clk);
      drive_op(op, addr, rt);
      exp_q.push_back(exp);
      @(negedge clk);
      drive_idle();
      if (mem_stall_o) stall_cycles++;
      check({tag, ":req"}, {31'd0, data_req_o}, 32'd1);
      check({tag, ":addr"}, data_addr_o, addr);
      check({tag, ":wr"}, {31'd0, data_wr_o}, {31'd0, wr});
      check({tag, ":size"}, {30'd0, data_size_o}, {30'd0, size});
      if (wr) check({tag, ":wdata"}, data_wdata_o, wdata);
      data_addr_ok_i = 1'b1;
      @(negedge clk);
      if (mem_stall_o) stall_cycles++;
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b1;
      data_rdata_i   = rdata;
      @(negedge clk);
      data_data_ok_i = 1'b0;
      for (int i = 0; i < 8 && mem_stall_o; i++) begin
         stall_cycles++;
         @(negedge clk);
      end
      check({tag, ":stall_cycles"}, stall_cycles, 32'd2);
      e = exp_q.pop_front();
      check({tag, ":result"}, mem_wdata_o, e);
      check({tag, ":valid"}, {31'd0, mem_valid_o}, 32'd1);
   endtask

   initial begin
      rst            = 1'b0;
      stall_i        = 1'b0;
      flush_i        = 1'b0;
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b0;
      data_rdata_i   = '0;
      drive_idle();
      repeat (3) @(negedge clk);
      check("rst:stall", {31'd0, mem_stall_o}, 32'd0);
      check("rst:req", {31'd0, data_req_o}, 32'd0);
      check("rst:valid", {31'd0, mem_valid_o}, 32'd0);
      check("rst:wdata", mem_wdata_o, 32'd0);
      check("rst:pc", mem_pc_o, 32'd0);
      check("rst:exc", {30'd0, adel_o, ades_o}, 32'd0);
      rst = 1'b1;

      run_mem("lw", OpLw, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0, SZ_W, 32'h0, 32'hDEADBEEF);
      check("lw:we", {31'd0, mem_we_o}, 32'd1);
      check("lw:waddr", {27'd0, mem_waddr_o}, 32'd7);
      check("lw:pc", mem_pc_o, 32'hBFC0_1000);
      check("lw:hi", mem_hi_alu_out_o, 32'hFFFF_1000);
      check("lw:hilo_we", {30'd0, mem_hilo_we_o}, 32'd2);
      check("lw:rd_wcp0", {26'd0, mem_rd_o, mem_wcp0_o}, {26'd0, 5'd12, 1'b1});

      run_mem("lb", OpLb, 32'h1003, 32'h0, 32'h80FF0000, 1'b0, SZ_B, 32'h0, 32'hFFFFFF80);
      run_mem("lbu", OpLbu, 32'h1003, 32'h0, 32'h80FF0000, 1'b0, SZ_B, 32'h0, 32'h00000080);
      run_mem("lh", OpLh, 32'h1002, 32'h0, 32'h80FF0000, 1'b0, SZ_H, 32'h0, 32'hFFFF80FF);
      run_mem("lhu", OpLhu, 32'h1000, 32'h0, 32'h1234ABCD, 1'b0, SZ_H, 32'h0, 32'h0000ABCD);
      run_mem("sh", OpSh, 32'h2002, 32'h1234ABCD, 32'h0, 1'b1, SZ_H, 32'hABCDABCD, 32'h2002);
      run_mem("sb", OpSb, 32'h2001, 32'h00000055, 32'h0, 1'b1, SZ_B, 32'h55555555, 32'h2001);
      run_mem("sw", OpSw, 32'h2004, 32'hCAFE1234, 32'h0, 1'b1, SZ_W, 32'hCAFE1234, 32'h2004);

      // Misaligned load then store: exception flags, no bus traffic, no stall.
      @(negedge clk);
      drive_op(OpLw, 32'h1002, 32'h0);
      @(negedge clk);
      drive_idle();
      stall_i = 1'b1;
      check("adel:flag", {31'd0, adel_o}, 32'd1);
      check("adel:ades", {31'd0, ades_o}, 32'd0);
      check("adel:badvaddr", badvaddr_o, 32'h1002);
      check("adel:we", {31'd0, mem_we_o}, 32'd0);
      check("adel:stall", {31'd0, mem_stall_o}, 32'd0);
      check("adel:req", {31'd0, data_req_o}, 32'd0);
      @(negedge clk);
      check("adel:req_held", {31'd0, data_req_o}, 32'd0);
      stall_i = 1'b0;
      drive_op(OpSw, 32'h1001, 32'h0);
      @(negedge clk);
      drive_idle();
      check("ades:flag", {31'd0, ades_o}, 32'd1);
      check("ades:adel", {31'd0, adel_o}, 32'd0);
      check("ades:badvaddr", badvaddr_o, 32'h1001);
      check("ades:req", {31'd0, data_req_o}, 32'd0);

      // Flush while waiting for the response: CANCEL swallows the late data.
      @(negedge clk);
      drive_op(OpLw, 32'h3000, 32'h0);
      @(negedge clk);
      drive_idle();
      data_addr_ok_i = 1'b1;
      @(negedge clk);
      data_addr_ok_i = 1'b0;
      check("cancel:wait_stall", {31'd0, mem_stall_o}, 32'd1);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("cancel:stall1", {31'd0, mem_stall_o}, 32'd1);
      check("cancel:valid", {31'd0, mem_valid_o}, 32'd0);
      check("cancel:we", {31'd0, mem_we_o}, 32'd0);
      @(negedge clk);
      check("cancel:stall2", {31'd0, mem_stall_o}, 32'd1);
      @(negedge clk);
      check("cancel:stall3", {31'd0, mem_stall_o}, 32'd1);
      data_data_ok_i = 1'b1;
      data_rdata_i   = 32'h11111111;
      @(negedge clk);
      data_data_ok_i = 1'b0;
      check("cancel:released", {31'd0, mem_stall_o}, 32'd0);
      check("cancel:valid_after", {31'd0, mem_valid_o}, 32'd0);
      check("cancel:result", mem_wdata_o, 32'h3000);
      run_mem("after_cancel", OpLw, 32'h1000, 32'h0, 32'hCAFEF00D, 1'b0, SZ_W, 32'h0,
              32'hCAFEF00D);

      // Asynchronous reset in WAIT; a late data_ok must be ignored.
      @(negedge clk);
      drive_op(OpLw, 32'h1000, 32'h0);
      @(negedge clk);
      drive_idle();
      data_addr_ok_i = 1'b1;
      @(negedge clk);
      data_addr_ok_i = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst:stall", {31'd0, mem_stall_o}, 32'd0);
      check("arst:valid", {31'd0, mem_valid_o}, 32'd0);
      check("arst:req", {31'd0, data_req_o}, 32'd0);
      check("arst:wdata", mem_wdata_o, 32'd0);
      check("arst:pc", mem_pc_o, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      data_data_ok_i = 1'b1;
      data_rdata_i   = 32'h77777777;
      @(negedge clk);
      data_data_ok_i = 1'b0;
      check("arst:late_stall", {31'd0, mem_stall_o}, 32'd0);
      check("arst:late_valid", {31'd0, mem_valid_o}, 32'd0);
      check("arst:late_wdata", mem_wdata_o, 32'd0);
      check("arst:late_req", {31'd0, data_req_o}, 32'd0);
      check("sb:empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
